// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with result flags, an accumulator that can
// replace operand A, and a multi-cycle shift-add multiplier.
module alu_seq #(
    parameter int width = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [3:0]       sel,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] x,
    output logic             carry,
    output logic             zero,
    output logic [width-1:0] acc
);

    localparam int CW = $clog2(width + 1);
    localparam logic [width-1:0] W_LIM = width[width-1:0];
    localparam logic [CW-1:0]    CNT_INIT = CW'(width);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [width-1:0]     x_q, x_d, acc_q, acc_d;
    logic                 carry_q, carry_d, zero_q, zero_d;
    logic [2*width-1:0]   ma_q, ma_d, prod_q, prod_d;
    logic [width-1:0]     mb_q, mb_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept, xfer, mul_done;
    logic [width-1:0]     op_a, res_x;
    logic                 res_c;
    logic [width:0]       sum_w;
    logic [2*width-1:0]   prod_step;

    assign op_a      = acc_en ? acc_q : a;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;
    assign sum_w     = {1'b0, op_a} + {1'b0, b};
    assign prod_step = prod_q + (mb_q[0] ? ma_q : '0);
    assign mul_done  = (state_q == MUL) && (cnt_q == CNT_LAST);

    // Output decode: accept only when idle and the output slot is free or draining.
    always_comb begin
        in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    end

    // Single-cycle opcode results from the selected operand A and B.
    always_comb begin
        res_x = '0;
        res_c = 1'b0;
        case (sel)
            4'd0:    begin res_x = sum_w[width-1:0]; res_c = sum_w[width]; end
            4'd1:    res_x = (op_a > b) ? (op_a - b) : (b - op_a);
            4'd2:    res_x = {{(width-1){1'b0}}, (op_a > b)};
            4'd3:    res_x = op_a & b;
            4'd4:    res_x = op_a | b;
            4'd5:    res_x = op_a ^ b;
            4'd7:    res_x = b;
            4'd9:    begin res_x = op_a - b; res_c = (op_a < b); end
            4'd10:   res_x = (b >= W_LIM) ? '0 : (op_a << b);
            4'd11:   res_x = (b >= W_LIM) ? '0 : (op_a >> b);
            4'd15:   res_x = '0;
            default: res_x = op_a;   // 6, reserved 12-14, and 8 (unused here)
        endcase
    end

    // Next-state: handshake, result load, and multiplier stepping.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        acc_d       = acc_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        if (state_q == IDLE) begin
            if (xfer)
                out_valid_d = 1'b0;
            if (accept) begin
                if (sel == 4'd8) begin
                    state_d = MUL;
                    ma_d    = {{width{1'b0}}, op_a};
                    mb_d    = b;
                    prod_d  = '0;
                    cnt_d   = CNT_INIT;
                end else begin
                    out_valid_d = 1'b1;
                    x_d         = res_x;
                    carry_d     = res_c;
                    zero_d      = (res_x == '0);
                    acc_d       = res_x;
                end
            end
        end else begin
            // One shift-add step per edge; the last step also publishes the product.
            prod_d = prod_step;
            ma_d   = ma_q << 1;
            mb_d   = mb_q >> 1;
            cnt_d  = cnt_q - CNT_LAST;
            if (mul_done) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                x_d         = prod_step[width-1:0];
                carry_d     = |prod_step[2*width-1:width];
                zero_d      = (prod_step[width-1:0] == '0);
                acc_d       = prod_step[width-1:0];
            end
        end
    end

    // State register; reset drops any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Result, accumulator and multiplier datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            x_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign acc       = acc_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, handshaked successor to the combinational ALU. It has a parametrised datapath width, an extended opcode set, result flags, and an accumulator that can stand in for operand A. It adds a multi-cycle shift-add multiplier. It sits between an operand producer and a result consumer, using valid/ready on both sides, and a registered output holds each result until the consumer takes it.

## Interface
- `width`, default 6: data bit count for `a`, `b`, `x`, `acc`; legal range 2..32.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: operands, opcode and `acc_en` are valid this cycle.
- `in_ready` output, 1 bit: block can accept an operation this cycle.
- `a` input, `width` bits: operand A, unsigned.
- `b` input, `width` bits: operand B, unsigned.
- `sel` input, 4 bits: opcode.
- `acc_en` input, 1 bit: when 1, the accumulator replaces `a` as operand A.
- `out_valid` output, 1 bit: `x`, `carry` and `zero` hold a result.
- `out_ready` input, 1 bit: consumer accepts the result this cycle.
- `x` output, `width` bits: registered result.
- `carry` output, 1 bit: carry, borrow or overflow flag for the result.
- `zero` output, 1 bit: 1 when `x` is 0.
- `acc` output, `width` bits: accumulator contents.

## Operation
- Accept: an operation is accepted on an edge where `in_valid && in_ready`. Result transfer happens on an edge where `out_valid && out_ready`.
- `in_ready` is `!rst && state==IDLE && (!out_valid || out_ready)`. It is combinational, with no dependency on `in_valid`.
- Operand A, called A' below, is `acc` when `acc_en=1`, otherwise `a`.
- Opcodes; all arithmetic is unsigned and `x` is truncated to `width` bits:
  - 0 add: A'+B; `carry` = carry-out.
  - 1 absolute difference |A'−B|; `carry`=0.
  - 2 greater-than: `x`=1 if A'>B, else 0.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 pass A'.
  - 7 pass B.
  - 8 multiply, multi-cycle: `x` = low `width` bits of A'×B; `carry` = 1 if any high product bit is 1.
  - 9 subtract A'−B: `carry` = borrow, i.e. A'<B.
  - 10 shift left logical A'<<B: B≥`width` gives 0.
  - 11 shift right logical A'>>B: B≥`width` gives 0.
  - 12–14 reserved: behave as pass A'.
  - 15 clear: `x`=0, `acc`=0.
- `carry`=0 for every opcode not listed with a carry rule above.
- `zero` is computed from the final `x` of every op.
- Accumulator: every produced result, including clear, is written to `acc` on the same edge that loads `x`. An op accepted on the following cycle with `acc_en=1` sees the new value.
- State machine:
  - IDLE: single-cycle ops compute combinationally and load `x`/flags/`acc` on the accept edge.
  - IDLE→MUL on accepting sel=8: latch A', B, clear the partial product, set the step counter to `width`.
  - MUL: one shift-add step per edge, counter decrements.
  - MUL→IDLE on the edge where the counter reaches 0: load `x`, flags and `acc`; set `out_valid`.
- Output hold: while `out_valid && !out_ready`, `x`, `carry`, `zero` and `acc` are frozen and `in_ready`=0.
- Simultaneous events: on the same edge, a transfer out plus a new single-cycle accept both happen. `out_valid` stays 1 and `x` takes the new result.
- Reset, at any time including mid-MUL:
  - `state`=IDLE, `out_valid`=0, `x`=0, `carry`=0, `zero`=0, `acc`=0.
  - A multiply in flight is discarded and produces no output.

## Timing
- Single-cycle ops: result and `out_valid` are visible the cycle after the accept edge (latency 1). With `out_ready` held high, throughput is 1 op/cycle.
- Multiply: accept on edge E0, steps on E1..E`width`. Result is visible after E`width`, giving latency `width`+1 cycles.
- During MUL, `in_ready`=0. `out_valid`=0, because a MUL can only be accepted when the previous result drains on E0.
- `out_valid` falls on the transfer edge unless a new result loads on that same edge.
- The first accept is possible in the cycle after `rst` deasserts.

## Test plan (width=6)
- Add with carry: add 40+30 → `x`=6, `carry`=1, `zero`=0, `out_valid` one cycle after accept. Subtract 5−9 → `x`=60, `carry`=1.
- Multiply:
  - 7×9 → `x`=63, `carry`=0, `out_valid` exactly 7 cycles after accept, `in_ready`=0 during cycles 1–6.
  - 9×9 → `x`=17, `carry`=1.
- Accumulate: clear (sel=15), then three back-to-back add ops with `acc_en`=1, `b`=5 → `x` and `acc` step 5, 10, 15 on consecutive cycles. Another add with `b`=49 → `x`=0, `zero`=1, `carry`=1.
- Backpressure: hold `out_ready`=0 for 4 cycles after an XOR 0x2A^0x0F → `x`=0x25 stable, `in_ready`=0. Release → transfer occurs and the next op is accepted on the same edge.
- Shifts: shl 3 by 2 → 12; shl 3 by 6 → 0 with `zero`=1; shr 48 by 4 → 3.
- Reset mid-multiply: assert `rst` for 1 cycle at step 3 of 7×9 → `out_valid` never rises for it, `acc`=0, `in_ready`=1 the cycle after `rst` deasserts.
